pipe_mem_stage: RTL and testbench
=================================

PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max cycles in WAIT before abort (used only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 clrn  input  1  reset, asynchronous, active-high.
REQ-004 mwreg, mm2reg, mwmem  input  1 each  MEM-stage controls: register write, load, store.
REQ-005 malu  input  32  ALU result / effective address.
REQ-006 mb  input  32  store data.
REQ-007 mrn  input  5  destination register number.
REQ-008 dmem_req  output  1  data-memory request.
REQ-009 dmem_we  output  1  write enable, 1 = store.
REQ-010 dmem_addr  output  32  word address.
REQ-011 dmem_wdata  output  32  store data.
REQ-012 dmem_rdata  input  32  load data, valid when dmem_ack = 1.
REQ-013 dmem_ack  input  1  access complete, single-cycle pulse.
REQ-014 mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-015 wwreg, wm2reg  output  1 each  MEM/WB controls.
REQ-016 wmo  output  32  registered load data.
REQ-017 walu  output  32  registered ALU result.
REQ-018 wrn  output  5  registered destination register.
REQ-019 mem_err  output  1  access-timeout pulse; present only with MEM_TIMEOUT_EN.

Function
REQ-020 Memory op: op = mm2reg | mwmem; loads and stores share one FSM, states IDLE and WAIT.
REQ-021 dmem_req = (IDLE & op) | WAIT; dmem_we = mwmem; dmem_addr = {malu[31:2], 2'b00}; dmem_wdata = mb.
REQ-022 IDLE -> WAIT when op & ~dmem_ack.
REQ-023 WAIT -> IDLE on dmem_ack.
REQ-024 IDLE with op & dmem_ack completes in the same cycle; state stays IDLE.
REQ-025 mem_stall = dmem_req & ~dmem_ack, combinational.
REQ-026 Non-op cycle (op = 0): MEM/WB register loads wwreg <= mwreg, wm2reg <= 0, walu <= malu, wrn <= mrn; wmo holds; latency 1 cycle.
REQ-027 Completion cycle (dmem_req & dmem_ack): wwreg <= mwreg, wm2reg <= mm2reg, walu <= malu, wrn <= mrn, wmo <= dmem_rdata (load only; wmo holds on store).
REQ-028 Stall cycle: wwreg <= 0 and wm2reg <= 0 (bubble); walu, wmo, wrn hold.
REQ-029 Inputs are held by upstream while mem_stall = 1; the block does not latch them.
REQ-030 A dmem_ack arriving while dmem_req = 0 is ignored.

Reset
REQ-031 clrn = 1 forces state IDLE, timeout counter 0, wwreg = wm2reg = 0, wmo = walu = 0, wrn = 0, mem_err = 0.
REQ-032 Reset during WAIT aborts the access: dmem_req falls immediately and no writeback occurs.

Configuration
REQ-033 Macro MEM_TIMEOUT_EN compiles in the timeout watchdog and the mem_err port.
REQ-034 With the macro: the counter clears on entry to WAIT and increments each WAIT cycle without ack.
REQ-035 With the macro: on reaching TIMEOUT_CYCLES, the FSM returns to IDLE, commits a bubble (wwreg = 0), and pulses mem_err for 1 cycle; mem_stall deasserts that cycle.
REQ-036 With the macro: ack in the same cycle as the limit wins; the access completes normally and mem_err stays 0.
REQ-037 Without the macro: WAIT persists until ack; there is no counter and no mem_err port.

Structure
REQ-038 Shared package pipe_pkg holds WORD_W = 32, REG_W = 5, and the FSM state enum (IDLE, WAIT).
REQ-039 The MEM/WB register is a sub-module, mem_wb_reg, with load and bubble inputs; the FSM and memory interface stay in the top module.

Verification
REQ-040 ALU op: mwreg = 1, malu = 0x1234, mrn = 7, no op -> next cycle wwreg = 1, walu = 0x1234, wrn = 7, mem_stall never 1.
REQ-041 Zero-wait load: mm2reg = 1, malu = 0x40, ack same cycle with rdata = 0xDEADBEEF -> wmo = 0xDEADBEEF, wm2reg = 1 next cycle, no stall.
REQ-042 3-wait store: mwmem = 1, malu = 0x43, mb = 0x55 -> dmem_addr = 0x40, dmem_we = 1; mem_stall high for 3 cycles with wwreg = 0; after ack, wmo unchanged.
REQ-043 Reset in WAIT: assert clrn 2 cycles into a load -> dmem_req = 0 immediately, all outputs 0, state IDLE.
REQ-044 MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> mem_err pulses once after 4 WAIT cycles, wwreg = 0, stall released.
REQ-045 MEM_TIMEOUT_EN: ack on the 4th WAIT cycle -> normal completion, mem_err = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, the MEM-stage access
// state encoding and a word-alignment helper for data-memory addresses.
package pipe_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    // IDLE: no access outstanding (or one completing this cycle).
    // WAIT: request issued, waiting for the data memory to acknowledge.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Data memory is word addressed; the byte offset bits are dropped.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write-back controls so a
// stalled or aborted access never writes the register file. The data fields
// hold during a bubble. A load moves the MEM-stage values across, and the
// load-data field only updates when a load actually completes.
module mem_wb_reg
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              load,
    input  logic              bubble,
    input  logic              load_mo,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic [WORD_W-1:0] mdata,
    input  logic [WORD_W-1:0] malu,
    input  logic [REG_W-1:0]  mrn,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [WORD_W-1:0] wmo,
    output logic [WORD_W-1:0] walu,
    output logic [REG_W-1:0]  wrn
);

    // Write-back controls: bubble has priority over a normal load.
    always_ff @(posedge clk or posedge clrn) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // its pre-edge inputs, independent of statement order.
        if (clrn) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
        end else if (bubble) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
        end else if (load) begin
            wwreg  <= mwreg;
            wm2reg <= mm2reg;
        end
    end

    // Data fields: ALU result and destination follow a load, hold on bubble.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            walu <= '0;
            wrn  <= '0;
        end else if (load && !bubble) begin
            walu <= malu;
            wrn  <= mrn;
        end
    end

    // Load data: captured only on a completing load, otherwise held.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            wmo <= '0;
        end else if (load_mo && !bubble) begin
            wmo <= mdata;
        end
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage of the pipeline: a single IDLE/WAIT handshake FSM drives the
// data-memory request for loads and stores. It raises mem_stall until the
// access is acknowledged and feeds the MEM/WB register (mem_wb_reg).
// Optional build macro MEM_TIMEOUT_EN adds a watchdog. An access that waits
// TIMEOUT_CYCLES cycles without an ack is abandoned. The abandoned access
// commits as a bubble and pulses mem_err for one cycle.
module pipe_mem_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [WORD_W-1:0] malu,
    input  logic [WORD_W-1:0] mb,
    input  logic [REG_W-1:0]  mrn,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic [WORD_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [WORD_W-1:0] wmo,
    output logic [WORD_W-1:0] walu,
    output logic [REG_W-1:0]  wrn
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              mem_err
`endif
);

    // The watchdog compare needs at least one WAIT cycle to count.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("pipe_mem_stage: TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_e state;
    mem_state_e next_state;

    logic op;        // a load or store occupies the MEM stage
    logic done;      // the access completes this cycle
    logic timeout;   // the watchdog abandons the access this cycle
    logic wb_load;
    logic wb_bubble;
    logic wb_load_mo;

    assign op = mm2reg | mwmem;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // cnt holds the number of WAIT cycles already spent without an ack.
    logic [CNT_W-1:0] cnt;

    // An ack in the limit cycle wins over the timeout.
    assign timeout = (state == WAIT) && !dmem_ack && (cnt == CNT_LAST);

    // Watchdog counter: cleared in IDLE, so it starts at zero on entry to
    // WAIT. It then counts each WAIT cycle that passes without an ack.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (!dmem_ack) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Error pulse: registered, high for the one cycle after an abandoned access.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Access state register.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and memory-interface outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch can be inferred.
        next_state = state;
        dmem_req   = 1'b0;
        dmem_we    = mwmem;
        dmem_addr  = word_align(malu);
        dmem_wdata = mb;
        done       = 1'b0;
        mem_stall  = 1'b0;

        // Reset kills an outstanding request at once, even while an op is present.
        if (!clrn) begin
            dmem_req = ((state == IDLE) && op) || (state == WAIT);
        end
        done      = dmem_req && dmem_ack;
        mem_stall = dmem_req && !dmem_ack && !timeout;

        case (state)
            IDLE: begin
                // An ack in the request cycle completes without leaving IDLE.
                if (op && !dmem_ack) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ack || timeout) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A non-memory instruction or a completed access advances MEM/WB.
    // A stall or an abandoned access inserts a bubble instead.
    assign wb_load    = !op || done;
    assign wb_bubble  = mem_stall || timeout;
    assign wb_load_mo = done && mm2reg;

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .clrn    (clrn),
        .load    (wb_load),
        .bubble  (wb_bubble),
        .load_mo (wb_load_mo),
        .mwreg   (mwreg),
        .mm2reg  (mm2reg),
        .mdata   (dmem_rdata),
        .malu    (malu),
        .mrn     (mrn),
        .wwreg   (wwreg),
        .wm2reg  (wm2reg),
        .wmo     (wmo),
        .walu    (walu),
        .wrn     (wrn)
    );

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Scoreboard bench for pipe_mem_stage. The driver issues directed MEM-stage
// vectors and queues the hand-computed writeback result of each one.
// The monitor watches mem_stall. On every stalled cycle it checks for a
// bubble. On every non-stalled cycle it pops the next expectation and checks
// the memory interface and the MEM/WB register. Build with
// +define+MEM_TIMEOUT_EN to include the watchdog vectors.
module tb_pipe_mem_stage;

    logic        clk;
    logic        clrn;
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [4:0]  mrn;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        wwreg;
    logic        wm2reg;
    logic [31:0] wmo;
    logic [31:0] walu;
    logic [4:0]  wrn;
`ifdef MEM_TIMEOUT_EN
    logic        mem_err;
`endif

    pipe_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .malu       (malu),
        .mb         (mb),
        .mrn        (mrn),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .mem_stall  (mem_stall),
        .wwreg      (wwreg),
        .wm2reg     (wm2reg),
        .wmo        (wmo),
        .walu       (walu),
        .wrn        (wrn)
`ifdef MEM_TIMEOUT_EN
        ,
        .mem_err    (mem_err)
`endif
    );

    typedef struct {
        int          stalls;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wwreg;
        logic        wm2reg;
        logic [31:0] wmo;
        logic [31:0] walu;
        logic [4:0]  wrn;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int stalls, input logic req, input logic we,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic ww, input logic wm, input logic [31:0] mo,
                                    input logic [31:0] alu, input logic [4:0] rn, input logic err);
        exp_t e;
        e.stalls = stalls; e.req = req;   e.we = we;    e.addr = addr; e.wdata = wdata;
        e.wwreg  = ww;     e.wm2reg = wm; e.wmo = mo;   e.walu = alu;  e.wrn = rn;
        e.err    = err;
        return e;
    endfunction

    // Drive one MEM-stage instruction for ncyc cycles; ack is raised in cycle
    // ack_at (-1 = never). Starts and ends just after a rising edge.
    task automatic run_op(input logic wreg, input logic m2reg, input logic wmem,
                          input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                          input logic [31:0] rdata, input int ack_at, input int ncyc,
                          input exp_t e);
        q.push_back(e);
        mwreg = wreg; mm2reg = m2reg; mwmem = wmem; malu = alu; mb = b; mrn = rn;
        for (int i = 0; i < ncyc; i++) begin
            dmem_ack   = (i == ack_at);
            dmem_rdata = (i == ack_at) ? rdata : 32'hBAD0_BAD0;
            @(posedge clk); #1;
        end
    endtask

    // Monitor: stalled cycles must commit bubbles; free cycles pop and compare.
    initial begin
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_stall) begin
                    stall_cnt++;
                    @(posedge clk); #2;
                    check("bubble_wwreg", 32'(wwreg), 32'd0);
                    check("bubble_wm2reg", 32'(wm2reg), 32'd0);
                end else begin
                    check("commit_has_expectation", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                        check("dmem_req", 32'(dmem_req), 32'(e.req));
                        check("dmem_we", 32'(dmem_we), 32'(e.we));
                        check("dmem_addr", dmem_addr, e.addr);
                        check("dmem_wdata", dmem_wdata, e.wdata);
                        @(posedge clk); #2;
                        check("wwreg", 32'(wwreg), 32'(e.wwreg));
                        check("wm2reg", 32'(wm2reg), 32'(e.wm2reg));
                        check("wmo", wmo, e.wmo);
                        check("walu", walu, e.walu);
                        check("wrn", 32'(wrn), 32'(e.wrn));
`ifdef MEM_TIMEOUT_EN
                        check("mem_err", 32'(mem_err), 32'(e.err));
`endif
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // Driver
    initial begin
        clrn = 1'b1;
        mwreg = 1'b0; mm2reg = 1'b1; mwmem = 1'b0;
        malu = 32'h0; mb = 32'h0; mrn = 5'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;

        // Reset state, with a load presented so the request gating is exercised.
        repeat (2) @(posedge clk);
        #1;
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_wwreg", 32'(wwreg), 32'd0);
        check("rst_wm2reg", 32'(wm2reg), 32'd0);
        check("rst_wmo", wmo, 32'd0);
        check("rst_walu", walu, 32'd0);
        check("rst_wrn", 32'(wrn), 32'd0);
`ifdef MEM_TIMEOUT_EN
        check("rst_mem_err", 32'(mem_err), 32'd0);
`endif
        mm2reg = 1'b0;
        @(negedge clk);
        clrn = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // ALU op: no memory access, one-cycle writeback, no stall.
        run_op(1, 0, 0, 32'h1234, 32'h0, 5'd7, 32'h0, -1, 1,
               mk_exp(0, 0, 0, 32'h1234, 32'h0, 1, 0, 32'h0, 32'h1234, 5'd7, 0));
        // Zero-wait load: ack in the request cycle.
        run_op(1, 1, 0, 32'h40, 32'h0, 5'd3, 32'hDEAD_BEEF, 0, 1,
               mk_exp(0, 1, 0, 32'h40, 32'h0, 1, 1, 32'hDEAD_BEEF, 32'h40, 5'd3, 0));
        // Three-cycle store to an unaligned address; wmo must hold.
        run_op(0, 0, 1, 32'h43, 32'h55, 5'd0, 32'h1111_2222, 3, 4,
               mk_exp(3, 1, 1, 32'h40, 32'h55, 0, 0, 32'hDEAD_BEEF, 32'h43, 5'd0, 0));
        // Stray ack with no request is ignored: wmo holds.
        run_op(1, 0, 0, 32'h8, 32'h0, 5'd9, 32'hCAFE_F00D, 0, 1,
               mk_exp(0, 0, 0, 32'h8, 32'h0, 1, 0, 32'hDEAD_BEEF, 32'h8, 5'd9, 0));
        // Two-wait load, unaligned address, top register number.
        run_op(1, 1, 0, 32'h1003, 32'h0, 5'd31, 32'h0BAD_CAFE, 2, 3,
               mk_exp(2, 1, 0, 32'h1000, 32'h0, 1, 1, 32'h0BAD_CAFE, 32'h1003, 5'd31, 0));
`ifdef MEM_TIMEOUT_EN
        // No ack: abandoned in the 4th WAIT cycle, bubble committed, data held.
        run_op(1, 1, 0, 32'h200, 32'h0, 5'd4, 32'h0, -1, 5,
               mk_exp(4, 1, 0, 32'h200, 32'h0, 0, 0, 32'h0BAD_CAFE, 32'h1003, 5'd31, 1));
        // Ack in the limit cycle wins: normal completion, no error.
        run_op(1, 1, 0, 32'h300, 32'h0, 5'd5, 32'h600D_F00D, 4, 5,
               mk_exp(4, 1, 0, 32'h300, 32'h0, 1, 1, 32'h600D_F00D, 32'h300, 5'd5, 0));
`else
        // Without the watchdog a long wait simply persists until the ack.
        run_op(1, 1, 0, 32'h300, 32'h0, 5'd5, 32'h600D_F00D, 20, 21,
               mk_exp(20, 1, 0, 32'h300, 32'h0, 1, 1, 32'h600D_F00D, 32'h300, 5'd5, 0));
`endif
        // Trailing ALU op after the wait.
        run_op(1, 0, 0, 32'h5A5, 32'h0, 5'd12, 32'h0, -1, 1,
               mk_exp(0, 0, 0, 32'h5A4, 32'h0, 1, 0, 32'h600D_F00D, 32'h5A5, 5'd12, 0));
        mon_en = 1'b0;
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        // Reset two cycles into a waiting load aborts it immediately.
        mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h80; mrn = 5'd2;
        dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check("wait_dmem_req", 32'(dmem_req), 32'd1);
        #2;
        clrn = 1'b1;
        #1;
        check("abort_dmem_req", 32'(dmem_req), 32'd0);
        check("abort_mem_stall", 32'(mem_stall), 32'd0);
        check("abort_wwreg", 32'(wwreg), 32'd0);
        check("abort_wm2reg", 32'(wm2reg), 32'd0);
        check("abort_wmo", wmo, 32'd0);
        check("abort_walu", walu, 32'd0);
        check("abort_wrn", 32'(wrn), 32'd0);
`ifdef MEM_TIMEOUT_EN
        check("abort_mem_err", 32'(mem_err), 32'd0);
`endif
        // After release with no op, an IDLE state shows no request.
        mwreg = 1'b0; mm2reg = 1'b0; malu = 32'h0; mrn = 5'd0;
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        check("post_reset_idle_req", 32'(dmem_req), 32'd0);
        check("post_reset_idle_stall", 32'(mem_stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
